// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler.
// Runs an optional zero-clear sweep of x1..LAST_ADDR after reset. It then
// shares the single write port round-robin among NREQ writeback sources.
// A write to address 0 or to an address above LAST_ADDR is accepted and
// discarded, and drop_pulse is raised for that cycle.
module regfile_wr_sched #(
  parameter int NREQ           = 3,
  parameter int AW             = 6,
  parameter int DW             = 32,
  parameter int LAST_ADDR      = 31,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               rf_wen,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               init_busy,
  output logic               drop_pulse
);

  localparam int unsigned    N    = NREQ;
  localparam int             PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0]  LAST = AW'(LAST_ADDR);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [AW-1:0] cnt;

  logic          grant;
  int unsigned   win;
  logic [PW-1:0] nxt_ptr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_drop;

  // Round-robin pick: first valid requester starting at ptr, wrapping mod NREQ
  always_comb begin
    logic found;
    found     = 1'b0;
    win       = 0;
    req_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant    = found && (state == ST_RUN) && !reset;
    sel_addr = req_addr[win*AW +: AW];
    sel_data = req_data[win*DW +: DW];
    sel_drop = (sel_addr == '0) || (sel_addr > LAST);
    nxt_ptr  = PW'((win + 1) % N);
    if (grant) req_ready[win] = 1'b1;
  end

  // Sweep/run sequencing with registered write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RESET_STATE;
      ptr        <= '0;
      cnt        <= AW'(1);
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      drop_pulse <= 1'b0;
      init_busy  <= CLEAR_ON_RESET;
    end else begin
      case (state)
        ST_INIT: begin
          rf_wen     <= 1'b1;
          rf_waddr   <= cnt;
          rf_wdata   <= '0;
          drop_pulse <= 1'b0;
          cnt        <= cnt + AW'(1);
          if (cnt == LAST) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end
        end
        default: begin
          rf_wen     <= 1'b0;
          drop_pulse <= 1'b0;
          if (grant) begin
            ptr      <= nxt_ptr;
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
            if (sel_drop) drop_pulse <= 1'b1;
            else          rf_wen     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched. A small reference model predicts
// the ready vector each cycle. Expected write-port outputs go to a queue
// one cycle ahead and are checked when the DUT presents them.
module tb_regfile_wr_sched;

  localparam int NREQ = 3;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int LAST = 31;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          drop;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (clear sweep enabled)
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       ra [NREQ];
  logic [DW-1:0]       rd [NREQ];
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                rf_wen, init_busy, drop_pulse;
  logic [AW-1:0]       rf_waddr;
  logic [DW-1:0]       rf_wdata;

  assign req_addr = {ra[2], ra[1], ra[0]};
  assign req_data = {rd[2], rd[1], rd[0]};

  regfile_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .LAST_ADDR(LAST), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .init_busy(init_busy), .drop_pulse(drop_pulse)
  );

  // second DUT (no clear sweep)
  logic                b_reset;
  logic [NREQ-1:0]     b_valid;
  logic [NREQ-1:0]     b_ready;
  logic [NREQ*AW-1:0]  b_addr;
  logic [NREQ*DW-1:0]  b_data;
  logic                b_wen, b_busy, b_drop;
  logic [AW-1:0]       b_waddr;
  logic [DW-1:0]       b_wdata;

  regfile_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .LAST_ADDR(LAST), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
    .clk(clk), .reset(b_reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_addr(b_addr), .req_data(b_data), .rf_wen(b_wen), .rf_waddr(b_waddr),
    .rf_wdata(b_wdata), .init_busy(b_busy), .drop_pulse(b_drop)
  );

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;

  // reference model state
  exp_t          sb[$];
  bit            m_known = 1'b0;
  bit            m_run   = 1'b0;
  bit            m_busy  = 1'b1;
  int            m_cnt   = 1;
  int            m_ptr   = 0;
  logic [AW-1:0] m_la    = '0;
  logic [DW-1:0] m_ld    = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one clock cycle against the model, then advance the model and the clock
  task automatic cycle();
    int win;
    logic [NREQ-1:0] exp_ready;
    exp_t e;
    exp_t n;
    @(negedge clk);
    win = -1;
    exp_ready = '0;
    if (!reset && m_run)
      for (int k = 0; k < NREQ; k++) begin
        automatic int i = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[i]) win = i;
      end
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("ready", 64'(req_ready), 64'(exp_ready));
    if (m_known) begin
      e = sb.pop_front();
      chk("rf_wen", 64'(rf_wen), 64'(e.wen));
      chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
      chk("drop_pulse", 64'(drop_pulse), 64'(e.drop));
      chk("init_busy", 64'(init_busy), 64'(m_busy));
    end
    if (rf_wen === 1'b1) wen_cnt++;
    if (reset) begin
      sb.delete();
      n = '{wen: 1'b0, addr: '0, data: '0, drop: 1'b0};
      m_known = 1'b1; m_run = 1'b0; m_busy = 1'b1; m_cnt = 1; m_ptr = 0;
      m_la = '0; m_ld = '0;
    end else if (!m_run) begin
      n = '{wen: 1'b1, addr: AW'(m_cnt), data: '0, drop: 1'b0};
      m_la = AW'(m_cnt); m_ld = '0;
      if (m_cnt == LAST) begin m_run = 1'b1; m_busy = 1'b0; end
      m_cnt++;
    end else if (win >= 0) begin
      n.addr = ra[win];
      n.data = rd[win];
      n.drop = (ra[win] == 0) || (int'(ra[win]) > LAST);
      n.wen  = !n.drop;
      m_la = n.addr; m_ld = n.data;
      m_ptr = (win + 1) % NREQ;
    end else begin
      n = '{wen: 1'b0, addr: m_la, data: m_ld, drop: 1'b0};
    end
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ra[i] = a;
    rd[i] = d;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rd[i] = '0; end
    b_reset = 1'b1; b_valid = '0; b_addr = '0; b_data = '0;

    // reset, then a full clear sweep with no requests
    cycle(); cycle();
    reset = 1'b0;
    wen_cnt = 0;
    repeat (34) cycle();
    chk("sweep_len", 64'(wen_cnt), 64'(31));

    // all three requesters valid continuously
    set_req(0, 6'd5, 32'hA); set_req(1, 6'd6, 32'hB); set_req(2, 6'd7, 32'hC);
    req_valid = 3'b111;
    repeat (9) cycle();
    req_valid = '0;
    cycle();

    // lone requester 2 at the top address with ptr at 0
    set_req(2, 6'd31, 32'hDEADBEEF);
    req_valid = 3'b100;
    cycle();
    req_valid = '0;
    cycle(); cycle();

    // out-of-range writes from requester 1 are dropped
    set_req(1, 6'd0, 32'h1234);
    req_valid = 3'b010;
    cycle();
    set_req(1, 6'd32, 32'h5678);
    cycle();
    req_valid = '0;
    cycle(); cycle();

    // reset in RUN right after a handshake: the registered write still shows
    set_req(0, 6'd9, 32'h11);
    req_valid = 3'b001;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req_valid = '0;
    repeat (12) cycle();

    // reset mid-sweep restarts at address 1; held request waits for RUN
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_req(0, 6'd5, 32'h77);
    req_valid = 3'b001;
    wen_cnt = 0;
    repeat (32) cycle();
    chk("sweep_restart_len", 64'(wen_cnt), 64'(31));
    repeat (3) cycle();
    req_valid = '0;
    cycle(); cycle();

    // no-sweep instance: ready on the first post-reset cycle
    b_reset = 1'b1;
    b_valid = 3'b001;
    b_addr  = {6'd0, 6'd0, 6'd9};
    b_data  = {32'd0, 32'd0, 32'h55};
    @(negedge clk);
    chk("nc_ready_in_reset", 64'(b_ready), 64'(0));
    @(posedge clk); #1;
    b_reset = 1'b0;
    @(negedge clk);
    chk("nc_init_busy", 64'(b_busy), 64'(0));
    chk("nc_ready", 64'(b_ready), 64'(3'b001));
    chk("nc_wen_idle", 64'(b_wen), 64'(0));
    @(posedge clk); #1;
    b_valid = '0;
    @(negedge clk);
    chk("nc_wen", 64'(b_wen), 64'(1));
    chk("nc_waddr", 64'(b_waddr), 64'(9));
    chk("nc_wdata", 64'(b_wdata), 64'(32'h55));
    chk("nc_ready_idle", 64'(b_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("nc_wen_off", 64'(b_wen), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
